// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default sizes,
// the clear-sequencer state encoding and packed-port lane slicing.
package regfile_pkg;

   localparam int RF_DATA_W = 32;
   localparam int RF_DEPTH  = 32;

   typedef enum logic {
      RF_IDLE  = 1'b0,
      RF_SWEEP = 1'b1
   } rf_state_t;

   // LSB of lane 'lane' inside a packed vector of 'width'-bit lanes.
   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Self-timed clear sequencer: walks a pointer over every entry once per
// clr_req, reports busy, and flags writes that arrive during the sweep.
module regfile_clr_seq
   import regfile_pkg::*;
#(
   parameter int DEPTH  = RF_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_req,
   input  logic              we,
   output logic              busy,
   output logic              wr_drop,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

   rf_state_t         state;
   logic [ADDR_W-1:0] ptr;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= RF_IDLE;
         ptr     <= '0;
         busy    <= 1'b0;
         wr_drop <= 1'b0;
      end else begin
         wr_drop <= we && busy;
         case (state)
            RF_IDLE: begin
               if (clr_req) begin
                  state <= RF_SWEEP;
                  ptr   <= '0;
                  busy  <= 1'b1;
               end
            end
            RF_SWEEP: begin
               // End on an explicit compare so non-wrapping depths stay correct.
               if (ptr == PTR_LAST) begin
                  state <= RF_IDLE;
                  ptr   <= '0;
                  busy  <= 1'b0;
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
            default: begin
               state <= RF_IDLE;
               ptr   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign clr_we   = (state == RF_SWEEP);
   assign clr_addr = ptr;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with registered reads, optional
// hardwired-zero entry and clear sweep. Define REGFILE_BYPASS_EN to forward
// same-edge writes to matching read lanes.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int DEPTH    = RF_DEPTH,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int NR       = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NR*ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0]    rd,
   input  logic                 we,
   input  logic [DATA_W-1:0]    indata,
   output logic [NR*DATA_W-1:0] rv,
   input  logic                 clr_req,
   output logic                 busy,
   output logic                 wr_drop
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              rd_is_zero;
   logic              wr_ok;

   regfile_clr_seq #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_clr_seq (
      .clk      (clk),
      .rst      (rst),
      .clr_req  (clr_req),
      .we       (we),
      .busy     (busy),
      .wr_drop  (wr_drop),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   assign rd_is_zero = (ZERO_REG != 0) && (rd == '0);
   assign wr_ok      = we && !busy && !rd_is_zero;

   // NOTE: the array is built from flops with async reset because a reset
   // must zero every entry; a RAM macro could not honour that.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clr_we) begin
         mem[clr_addr] <= '0;
      end else if (wr_ok) begin
         mem[rd] <= indata;
      end
   end

   for (genvar i = 0; i < NR; i++) begin : g_lane
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] lane_q;

      assign addr = rs[lane_lsb(i, ADDR_W) +: ADDR_W];

      // Clear and zero-entry rules win over forwarding.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            lane_q <= '0;
         end else if (busy) begin
            lane_q <= '0;
         end else if ((ZERO_REG != 0) && (addr == '0)) begin
            lane_q <= '0;
`ifdef REGFILE_BYPASS_EN
         end else if (wr_ok && (rd == addr)) begin
            lane_q <= indata;
`endif
         end else begin
            lane_q <= mem[addr];
         end
      end

      assign rv[lane_lsb(i, DATA_W) +: DATA_W] = lane_q;
   end

endmodule
